// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_e;

    localparam int unsigned DefAddrW = 17;
    localparam int unsigned DefDataW = 8;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo NUM_REQ.
module mem_arbiter_rr_picker #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic               valid,
    output logic [PTR_W-1:0]   grant
);

    int unsigned idx;

    always_comb begin
        valid = 1'b0;
        grant = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(ptr) + i) % NUM_REQ;
            if (!valid && req[idx]) begin
                valid = 1'b1;
                grant = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one byte-wide memory controller among NUM_REQ requesters.
// Define MEM_ARB_BOUNDS_CHECK_EN to suppress writes and flag err for addresses >= MEM_BYTES.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned ADDR_W    = DefAddrW,
    parameter int unsigned DATA_W    = DefDataW,
    parameter int unsigned MEM_BYTES = 65536
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        err,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    output logic [DATA_W-1:0]         mem_data_in,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_write_en,
    input  logic [DATA_W-1:0]         mem_data_out
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

`ifdef MEM_ARB_BOUNDS_CHECK_EN
    localparam bit BoundsChk = 1'b1;
`else
    localparam bit BoundsChk = 1'b0;
`endif

    localparam logic [ADDR_W:0] MemLimit = (ADDR_W + 1)'(MEM_BYTES);

    state_e             state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   gnt_q;
    logic               rd_q;
    logic               oob_q;

    logic               pick_valid;
    logic [PTR_W-1:0]   pick;
    logic [ADDR_W-1:0]  addr_sel;
    logic [DATA_W-1:0]  wdata_sel;
    logic               oob;

    mem_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .grant (pick)
    );

    assign addr_sel  = addr[pick*ADDR_W +: ADDR_W];
    assign wdata_sel = wdata[pick*DATA_W +: DATA_W];
    assign oob       = BoundsChk && ({1'b0, addr_sel} >= MemLimit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            gnt_q        <= '0;
            rd_q         <= 1'b0;
            oob_q        <= 1'b0;
            ack          <= '0;
            err          <= '0;
            rdata        <= '0;
            busy         <= 1'b0;
            mem_write_en <= 1'b0;
            mem_addr     <= '0;
            mem_data_in  <= '0;
        end else begin
            ack <= '0;
            err <= '0;
            unique case (state_q)
                StIdle: begin
                    mem_write_en <= 1'b0;
                    if (pick_valid) begin
                        gnt_q        <= pick;
                        mem_addr     <= addr_sel;
                        mem_data_in  <= wdata_sel;
                        // Out-of-range winners still run the full sequence, just without a write.
                        mem_write_en <= we[pick] && !oob;
                        rd_q         <= !we[pick];
                        oob_q        <= oob;
                        busy         <= 1'b1;
                        state_q      <= StAccess;
                    end
                end
                StAccess: begin
                    mem_write_en <= 1'b0;
                    state_q      <= StDone;
                end
                StDone: begin
                    ack[gnt_q] <= 1'b1;
                    err[gnt_q] <= oob_q;
                    if (oob_q) begin
                        rdata <= '0;
                    end else if (rd_q) begin
                        rdata <= mem_data_out;
                    end
                    ptr_q   <= (gnt_q == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_q + PTR_W'(1);
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with three requesters and a registered-read memory model.
module tb_mem_arbiter;

    localparam int unsigned NR = 3;
    localparam int unsigned AW = 17;
    localparam int unsigned DW = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req = '0;
    logic [NR-1:0]     we = '0;
    logic [NR*AW-1:0]  addr = '0;
    logic [NR*DW-1:0]  wdata = '0;
    logic [NR-1:0]     ack;
    logic [NR-1:0]     err;
    logic [DW-1:0]     rdata;
    logic              busy;
    logic [DW-1:0]     mem_data_in;
    logic [AW-1:0]     mem_addr;
    logic              mem_write_en;
    logic [DW-1:0]     mem_data_out = '0;

    mem_arbiter #(
        .NUM_REQ   (NR),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MEM_BYTES (65536)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .we           (we),
        .addr         (addr),
        .wdata        (wdata),
        .ack          (ack),
        .err          (err),
        .rdata        (rdata),
        .busy         (busy),
        .mem_data_in  (mem_data_in),
        .mem_addr     (mem_addr),
        .mem_write_en (mem_write_en),
        .mem_data_out (mem_data_out)
    );

    always #5 clk = ~clk;

    // Memory controller model: no reset, write and read registered on the same edge.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_write_en) mem[mem_addr] <= mem_data_in;
        mem_data_out <= mem[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int         idx;
        logic       err;
        logic [7:0] rdata;
    } exp_t;

    exp_t q[$];
    bit   spacing_chk = 1'b0;
    bit   have_last = 1'b0;
    int   last_ack = 0;

    task automatic push_exp(input int i, input logic e, input logic [7:0] d);
        exp_t x;
        x.idx = i;
        x.err = e;
        x.rdata = d;
        q.push_back(x);
    endtask

    // Monitor: pops one expectation per ack pulse.
    always @(negedge clk) begin
        if (|ack) begin
            if (q.size() == 0) begin
                check("unexpected_ack", 32'(ack), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("ack_grant", 32'(ack), 32'(1) << e.idx);
                check("ack_err", 32'(err), e.err ? (32'(1) << e.idx) : 32'd0);
                check("ack_rdata", 32'(rdata), 32'(e.rdata));
            end
            if (spacing_chk && have_last) check("ack_spacing", 32'(cyc - last_ack), 32'd3);
            have_last = 1'b1;
            last_ack = cyc;
        end
    end

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        we[i] = w;
        addr[i*AW +: AW] = a;
        wdata[i*DW +: DW] = d;
        req[i] = 1'b1;
    endtask

    // Single transaction from an idle arbiter; checks latency and write-enable pulse count.
    task automatic txn(input string name, input int i, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic exp_err, input logic [DW-1:0] exp_rd,
                       input int exp_we);
        int  t0;
        int  wec;
        bit  seen;
        push_exp(i, exp_err, exp_rd);
        set_req(i, w, a, d);
        t0 = cyc;
        wec = 0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (mem_write_en) wec++;
            if (ack[i]) seen = 1'b1;
        end
        req[i] = 1'b0;
        check({name, "_ack_seen"}, 32'(seen), 32'd1);
        if (seen) check({name, "_latency"}, 32'(cyc - t0), 32'd3);
        check({name, "_we_cycles"}, 32'(wec), 32'(exp_we));
    endtask

    task automatic wait_acks(input string name, input int n);
        int cnt;
        cnt = 0;
        for (int k = 0; k < n * 3 + 10 && cnt < n; k++) begin
            @(posedge clk);
            #1;
            if (|ack) cnt++;
        end
        check({name, "_ack_count"}, 32'(cnt), 32'(n));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [DW-1:0] model_rd;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < (1 << AW); k++) mem[k] = 8'h00;
        mem[17'h00042] = 8'hA5;
        mem[17'h00010] = 8'h11;
        mem[17'h00020] = 8'h22;
        mem[17'h10000] = 8'h5A;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_we", 32'(mem_write_en), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_din", 32'(mem_data_in), 32'd0);
        rst = 1'b0;
        model_rd = 8'h00;

        // Single read
        txn("read42", 0, 1'b0, 17'h00042, 8'h00, 1'b0, 8'hA5, 0);
        model_rd = 8'hA5;

        // Write then read back; rdata holds across the write
        txn("write1234", 1, 1'b1, 17'h01234, 8'h3C, 1'b0, model_rd, 1);
        txn("read1234", 1, 1'b0, 17'h01234, 8'h00, 1'b0, 8'h3C, 0);
        model_rd = 8'h3C;
        check("mem_1234", 32'(mem[17'h01234]), 32'h3C);

        // Out-of-range write
`ifdef MEM_ARB_BOUNDS_CHECK_EN
        txn("oob_write", 0, 1'b1, 17'h10000, 8'hFF, 1'b1, 8'h00, 0);
        model_rd = 8'h00;
        check("mem_10000", 32'(mem[17'h10000]), 32'h5A);
`else
        txn("oob_write", 0, 1'b1, 17'h10000, 8'hFF, 1'b0, model_rd, 1);
        check("mem_10000", 32'(mem[17'h10000]), 32'hFF);
`endif

        // Reset during ACCESS of a read
        set_req(0, 1'b0, 17'h00042, 8'h00);
        @(posedge clk);
        #1;
        check("midrst_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        req = '0;
        @(posedge clk);
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_rdata", 32'(rdata), 32'd0);
        check("midrst_we", 32'(mem_write_en), 32'd0);
        check("midrst_addr", 32'(mem_addr), 32'd0);
        check("midrst_din", 32'(mem_data_in), 32'd0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        txn("post_rst_read", 0, 1'b0, 17'h00010, 8'h00, 1'b0, 8'h11, 0);

        // Contention from reset: 0,1,0,1 spaced three cycles
        rst = 1'b1;
        set_req(0, 1'b0, 17'h00010, 8'h00);
        set_req(1, 1'b0, 17'h00020, 8'h00);
        push_exp(0, 1'b0, 8'h11);
        push_exp(1, 1'b0, 8'h22);
        push_exp(0, 1'b0, 8'h11);
        push_exp(1, 1'b0, 8'h22);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        have_last = 1'b0;
        spacing_chk = 1'b1;
        wait_acks("contention", 4);
        req = '0;
        spacing_chk = 1'b0;

        // Move ptr to 2, then all three requesting: 2,0,1,2
        repeat (2) @(posedge clk);
        #1;
        txn("ptr_setup", 1, 1'b0, 17'h01234, 8'h00, 1'b0, 8'h3C, 0);
        set_req(0, 1'b0, 17'h00010, 8'h00);
        set_req(1, 1'b0, 17'h00020, 8'h00);
        set_req(2, 1'b0, 17'h00042, 8'h00);
        push_exp(2, 1'b0, 8'hA5);
        push_exp(0, 1'b0, 8'h11);
        push_exp(1, 1'b0, 8'h22);
        push_exp(2, 1'b0, 8'hA5);
        have_last = 1'b0;
        spacing_chk = 1'b1;
        wait_acks("rotate3", 4);
        req = '0;
        spacing_chk = 1'b0;

        repeat (6) @(posedge clk);
        #1;
        check("queue_drained", 32'(q.size()), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
